// File: rtl/axi_burst_addr_gen_pkg.sv
// ---------------------------------------------------------------------------
// axi_burst_addr_gen_pkg
// Shared types for the AXI-to-APB bridge burst path:
//   burst_t       AXI burst encoding (FIXED, INCR, WRAP, reserved)
//   state_t       burst expander FSM states
//   burst_desc_t  captured burst descriptor, sized for the widest (AXI4)
//                 length field so the read and write front-ends share it
//   is_wrap_len   legal WRAP beat counts (2, 4, 8, 16 beats)
// ---------------------------------------------------------------------------
package axi_burst_addr_gen_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'd0,
    BURST_INCR  = 2'd1,
    BURST_WRAP  = 2'd2,
    BURST_RSVD  = 2'd3
  } burst_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  localparam int DESC_ADDR_WIDTH = 32;
  localparam int DESC_LEN_WIDTH  = 8;

  typedef struct packed {
    logic [DESC_ADDR_WIDTH-1:0] addr;
    logic [DESC_LEN_WIDTH-1:0]  len;
    logic [2:0]                 size;
    burst_t                     burst;
  } burst_desc_t;

  // WRAP bursts are only defined for 2, 4, 8 or 16 beats.
  function automatic logic is_wrap_len(input logic [DESC_LEN_WIDTH-1:0] len);
    case (len)
      8'd1, 8'd3, 8'd7, 8'd15: return 1'b1;
      default:                 return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/axi_burst_addr_gen_lane_mask.sv
// ---------------------------------------------------------------------------
// axi_lane_mask
// Combinational byte-lane mask for one beat. The active window is the
// size-aligned block containing the address; lanes below the address itself
// are cleared, so only an unaligned beat loses lanes. Sizes at or above the
// bus width light every lane from the address upward.
// Ports:
//   addr_lo  in   low address bits (byte offset within the data bus)
//   size     in   log2(bytes per beat)
//   lanes    out  one bit per byte lane, bit 0 = lowest-addressed byte
// ---------------------------------------------------------------------------
module axi_lane_mask
  import axi_burst_addr_gen_pkg::*;
#(
  parameter  int DATA_WIDTH = 32,
  localparam int NBYTES     = DATA_WIDTH / 8,
  localparam int MAX_SIZE   = $clog2(NBYTES),
  localparam int LOW_W      = (MAX_SIZE > 0) ? MAX_SIZE : 1
) (
  input  logic [LOW_W-1:0]  addr_lo,
  input  logic [2:0]        size,
  output logic [NBYTES-1:0] lanes
);

  int off_i;
  int bytes_i;
  int win_end_i;

  // Window [aligned offset, aligned offset + bytes) intersected with lanes >= offset.
  always_comb begin
    lanes   = '0;
    off_i   = (MAX_SIZE > 0) ? int'(addr_lo) : 32'sd0;
    bytes_i = int'(32'd1 << size);
    if (int'(size) >= MAX_SIZE) begin
      win_end_i = NBYTES;
    end else begin
      win_end_i = (off_i & ~(bytes_i - 32'sd1)) + bytes_i;
    end
    for (int i = 0; i < NBYTES; i++) begin
      lanes[i] = (i >= off_i) && (i < win_end_i);
    end
  end

endmodule

// File: rtl/axi_burst_addr_gen.sv
// ---------------------------------------------------------------------------
// axi_burst_addr_gen
// Expands one AXI burst descriptor (addr/len/size/burst) into per-beat APB
// transfer descriptors: beat address, byte lanes, beat index, last and error.
// One bubble cycle always separates consecutive bursts (in_ready is only high
// in IDLE). All beat outputs are registered and hold while out_ready is low.
//
// Configuration macro: BRIDGE_WRAP_BURST_EN
//   defined     - legal WRAP bursts wrap within their (len+1)*bytes window
//   not defined - WRAP bursts are flagged out_err on every beat and walk
//                 INCR addresses; no wrap arithmetic is built
//
// Ports:
//   clk, rst_n       clock, synchronous active-low reset
//   in_valid/ready   descriptor handshake; in_addr, in_len, in_size, in_burst
//   out_valid/ready  beat handshake; out_addr, out_lanes, out_beat,
//                    out_last, out_err describe the current beat
// ---------------------------------------------------------------------------
module axi_burst_addr_gen
  import axi_burst_addr_gen_pkg::*;
#(
  parameter  int ADDR_WIDTH = 32,
  parameter  int DATA_WIDTH = 32,
  parameter  int LEN_WIDTH  = 4,
  localparam int NBYTES     = DATA_WIDTH / 8,
  localparam int MAX_SIZE   = $clog2(NBYTES),
  localparam int LOW_W      = (MAX_SIZE > 0) ? MAX_SIZE : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  input  logic [LEN_WIDTH-1:0]  in_len,
  input  logic [2:0]            in_size,
  input  logic [1:0]            in_burst,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic [NBYTES-1:0]     out_lanes,
  output logic [LEN_WIDTH-1:0]  out_beat,
  output logic                  out_last,
  output logic                  out_err
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [LEN_WIDTH-1:0]  LEN_ONE  = {{(LEN_WIDTH-1){1'b0}}, 1'b1};

  state_t                state;
  logic [LEN_WIDTH-1:0]  len_r;
  logic [2:0]            size_r;
  burst_t                mode_r;      // addressing mode actually used, after error demotion

  logic                  size_bad_s;
  logic                  in_err_s;
  burst_t                in_mode_s;
  logic [ADDR_WIDTH-1:0] bytes_s;
  logic [ADDR_WIDTH-1:0] aligned_s;
  logic [ADDR_WIDTH-1:0] incr_next_s;
  logic [ADDR_WIDTH-1:0] next_addr_s;
  logic [LOW_W-1:0]      mask_lo_s;
  logic [2:0]            mask_size_s;
  logic [NBYTES-1:0]     mask_lanes_s;

  // Held low during reset so no descriptor is taken while rst_n is asserted.
  assign in_ready   = rst_n && (state == ST_IDLE);
  assign size_bad_s = (in_size > 3'(MAX_SIZE));

  // out_addr doubles as the current beat address.
  assign bytes_s     = ADDR_ONE << size_r;
  assign aligned_s   = out_addr & ~(bytes_s - ADDR_ONE);
  assign incr_next_s = aligned_s + bytes_s;

`ifdef BRIDGE_WRAP_BURST_EN
  logic [ADDR_WIDTH-1:0] in_bytes_s;
  logic [ADDR_WIDTH-1:0] wrap_mask_s;
  logic [ADDR_WIDTH-1:0] wrap_next_s;

  assign in_bytes_s  = ADDR_ONE << in_size;
  assign wrap_mask_s = (({{(ADDR_WIDTH-LEN_WIDTH){1'b0}}, len_r} + ADDR_ONE) << size_r) - ADDR_ONE;
  assign wrap_next_s = (out_addr & ~wrap_mask_s) | ((out_addr + bytes_s) & wrap_mask_s);
`endif

  // Classify the incoming descriptor: error flag and the addressing mode to use.
  always_comb begin
    in_err_s  = 1'b0;
    in_mode_s = BURST_INCR;
    case (burst_t'(in_burst))
      BURST_FIXED: begin
        in_mode_s = BURST_FIXED;
        in_err_s  = size_bad_s;
      end
      BURST_INCR: begin
        in_err_s = size_bad_s;
      end
      BURST_WRAP: begin
`ifdef BRIDGE_WRAP_BURST_EN
        if (size_bad_s || !is_wrap_len(DESC_LEN_WIDTH'(in_len)) ||
            ((in_addr & (in_bytes_s - ADDR_ONE)) != '0)) begin
          in_err_s = 1'b1;
        end else begin
          in_mode_s = BURST_WRAP;
        end
`else
        in_err_s = 1'b1;
`endif
      end
      default: begin
        in_err_s = 1'b1;
      end
    endcase
  end

  // Address of the beat following the current one.
  always_comb begin
    case (mode_r)
      BURST_FIXED: next_addr_s = out_addr;
`ifdef BRIDGE_WRAP_BURST_EN
      BURST_WRAP:  next_addr_s = wrap_next_s;
`endif
      default:     next_addr_s = incr_next_s;
    endcase
  end

  // The single lane-mask unit serves the first beat in IDLE and later beats in BUSY.
  always_comb begin
    if (state == ST_IDLE) begin
      mask_lo_s   = in_addr[LOW_W-1:0];
      mask_size_s = in_size;
    end else begin
      mask_lo_s   = next_addr_s[LOW_W-1:0];
      mask_size_s = size_r;
    end
  end

  axi_lane_mask #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_lane_mask (
    .addr_lo (mask_lo_s),
    .size    (mask_size_s),
    .lanes   (mask_lanes_s)
  );

  // Burst FSM with registered beat outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      len_r     <= '0;
      size_r    <= 3'd0;
      mode_r    <= BURST_INCR;
      out_valid <= 1'b0;
      out_addr  <= '0;
      out_lanes <= '0;
      out_beat  <= '0;
      out_last  <= 1'b0;
      out_err   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            len_r     <= in_len;
            size_r    <= in_size;
            mode_r    <= in_mode_s;
            out_valid <= 1'b1;
            out_addr  <= in_addr;
            out_lanes <= mask_lanes_s;
            out_beat  <= '0;
            out_last  <= (in_len == '0);
            out_err   <= in_err_s;
            state     <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (out_ready) begin
            if (out_beat == len_r) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              out_err   <= 1'b0;
              state     <= ST_IDLE;
            end else begin
              out_addr  <= next_addr_s;
              out_lanes <= mask_lanes_s;
              out_beat  <= out_beat + LEN_ONE;
              out_last  <= ((out_beat + LEN_ONE) == len_r);
            end
          end
        end
        default: begin
          out_valid <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
